// File: rtl/key_event_ctrl.sv
// -----------------------------------------------------------------------------
// key_event_ctrl
//   Debounce / press sequencer for one active-low key. Consumes the falling and
//   rising edge pulses from detect_module plus the raw pin, and emits clean
//   one-cycle press, long-press and release events and a debounced key level.
//
// Parameters
//   T10MS   debounce window in clocks, minus 1
//   T_LONG  hold time from PRESSED entry to Key_Long, minus 1
//   T_REP   auto-repeat period, minus 1 (present only with KEY_REPEAT_EN)
//
// Ports
//   CLK          in   system clock
//   RSTn         in   asynchronous active-low reset
//   Pin_In       in   raw key pin, low = pressed
//   H2L_Sig      in   falling-edge pulse from detect_module
//   L2H_Sig      in   rising-edge pulse from detect_module
//   Key_Press    out  1-cycle debounced press (and auto-repeat pulses)
//   Key_Long     out  1-cycle long-press event
//   Key_Release  out  1-cycle debounced release
//   Key_State    out  1 while the key is debounced-down
//
// Build option
//   KEY_REPEAT_EN  when defined, HELD emits a Key_Press every T_REP+1 clocks.
//
// States
//   IDLE    | key up, waiting for a falling edge
//   DB_DOWN | debouncing a press, edges ignored
//   PRESSED | key down, timing towards Key_Long
//   HELD    | key down past the long-press time
//   DB_UP   | debouncing a release, edges ignored
// -----------------------------------------------------------------------------
module key_event_ctrl #(
  parameter logic [25:0] T10MS  = 26'd499_999,
  parameter logic [25:0] T_LONG = 26'd49_999_999
`ifdef KEY_REPEAT_EN
  , parameter logic [25:0] T_REP = 26'd9_999_999
`endif
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Pin_In,
  input  logic H2L_Sig,
  input  logic L2H_Sig,
  output logic Key_Press,
  output logic Key_Long,
  output logic Key_Release,
  output logic Key_State
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DB_DOWN = 3'd1,
    PRESSED = 3'd2,
    HELD    = 3'd3,
    DB_UP   = 3'd4
  } state_t;

  state_t      state_q;
  logic [25:0] cnt_q;
  logic        pin_s1_q, pin_s2_q;
  logic        h2l_q, l2h_q;
  logic        press_q, long_q, rel_q, down_q;
`ifdef KEY_REPEAT_EN
  logic [25:0] rep_q;
`endif

  // Pin synchroniser and edge-pulse capture share one register stage so the
  // FSM always acts on inputs from a common clock. Both pulses high at once is
  // not a legal detector output and is dropped here.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pin_s1_q <= 1'b1;
      pin_s2_q <= 1'b1;
      h2l_q    <= 1'b0;
      l2h_q    <= 1'b0;
    end else begin
      pin_s1_q <= Pin_In;
      pin_s2_q <= pin_s1_q;
      h2l_q    <= H2L_Sig & ~L2H_Sig;
      l2h_q    <= L2H_Sig & ~H2L_Sig;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
      rel_q   <= 1'b0;
      down_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      press_q <= 1'b0;
      long_q  <= 1'b0;
      rel_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      // Held at zero outside HELD so every HELD entry starts a fresh period.
      rep_q   <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (h2l_q) begin
            state_q <= DB_DOWN;
            cnt_q   <= '0;
          end
        end
        DB_DOWN: begin
          if (cnt_q == T10MS) begin
            cnt_q <= '0;
            if (!pin_s2_q) begin
              state_q <= PRESSED;
              press_q <= 1'b1;
              down_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 26'd1;
          end
        end
        PRESSED: begin
          // A release edge beats the long-press terminal count.
          if (l2h_q) begin
            state_q <= DB_UP;
            cnt_q   <= '0;
          end else if (cnt_q == T_LONG) begin
            state_q <= HELD;
            cnt_q   <= '0;
            long_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 26'd1;
          end
        end
        HELD: begin
          if (l2h_q) begin
            state_q <= DB_UP;
            cnt_q   <= '0;
          end
`ifdef KEY_REPEAT_EN
          else if (rep_q == T_REP) begin
            press_q <= 1'b1;
          end else begin
            rep_q <= rep_q + 26'd1;
          end
`endif
        end
        DB_UP: begin
          if (cnt_q == T10MS) begin
            cnt_q <= '0;
            if (pin_s2_q) begin
              state_q <= IDLE;
              rel_q   <= 1'b1;
              down_q  <= 1'b0;
            end else begin
              // Bounce: key is still down, return without re-arming Key_Long.
              state_q <= HELD;
            end
          end else begin
            cnt_q <= cnt_q + 26'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          down_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Key_Press   = press_q;
  assign Key_Long    = long_q;
  assign Key_Release = rel_q;
  assign Key_State   = down_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_event_ctrl
//   Directed table of press patterns, hand-written multi-cycle sequences
//   (long hold, release, release bounce, long/release collision, reset), then
//   random key activity checked cycle by cycle against a timeline model.
// -----------------------------------------------------------------------------
module tb_key_event_ctrl;

  localparam int T10MS  = 9;
  localparam int T_LONG = 49;
`ifdef KEY_REPEAT_EN
  localparam int T_REP  = 19;
  localparam int REP    = 1;
`else
  localparam int REP    = 0;
`endif
  localparam int M = 16383;

  logic CLK = 1'b0;
  logic RSTn, Pin_In, H2L_Sig, L2H_Sig;
  logic Key_Press, Key_Long, Key_Release, Key_State;

  key_event_ctrl #(
    .T10MS (26'd9),
    .T_LONG(26'd49)
`ifdef KEY_REPEAT_EN
    , .T_REP(26'd19)
`endif
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Pin_In     (Pin_In),
    .H2L_Sig    (H2L_Sig),
    .L2H_Sig    (L2H_Sig),
    .Key_Press  (Key_Press),
    .Key_Long   (Key_Long),
    .Key_Release(Key_Release),
    .Key_State  (Key_State)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- watcher
  int press_first, press_last, press_cnt;
  int long_first, long_cnt;
  int rel_first, rel_cnt;
  int overlap_cnt;
  bit st_hist [0:255];

  // Runs n clocks after a stimulus set at a negedge. Pulses last one clock.
  // Pin goes high after edge pin_hi_at; L2H pulses after edge l2h_at.
  task automatic watch(input int n, input int pin_hi_at, input int l2h_at);
    press_first = -1; press_last = -1; press_cnt = 0;
    long_first = -1; long_cnt = 0;
    rel_first = -1; rel_cnt = 0;
    overlap_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      H2L_Sig = 1'b0;
      L2H_Sig = 1'b0;
      if (i == pin_hi_at) Pin_In = 1'b1;
      if (i == l2h_at) L2H_Sig = 1'b1;
      if (Key_Press) begin
        if (press_first < 0) press_first = i;
        press_last = i;
        press_cnt++;
      end
      if (Key_Long) begin
        if (long_first < 0) long_first = i;
        long_cnt++;
      end
      if (Key_Release) begin
        if (rel_first < 0) rel_first = i;
        rel_cnt++;
      end
      if (int'(Key_Press) + int'(Key_Long) + int'(Key_Release) > 1) overlap_cnt++;
      st_hist[i] = Key_State;
    end
  endtask

  task automatic do_release(input string nm);
    Pin_In  = 1'b1;
    L2H_Sig = 1'b1;
    watch(14, 0, 0);
    chk({nm, "_rel_at"}, rel_first, 12);
    chk({nm, "_rel_cnt"}, rel_cnt, 1);
    chk({nm, "_state_before_rel"}, st_hist[11], 1);
    chk({nm, "_state_at_rel"}, st_hist[12], 0);
  endtask

  // ------------------------------------------------------ timeline model
  // The controller sees each detector pulse one clock after it arrives and
  // judges the pin as it stood two clocks before its decision edge.
  int cyc = 0;
  bit rand_on = 1'b0;
  bit pin_at [0:M];
  bit h2l_at [0:M];
  bit l2h_at [0:M];
  bit exp_press [0:M];
  bit exp_long  [0:M];
  bit exp_rel   [0:M];
  bit m_down = 1'b0;

  always @(posedge CLK) begin
    pin_at[cyc & M] = Pin_In;
    h2l_at[cyc & M] = H2L_Sig && !L2H_Sig;
    l2h_at[cyc & M] = L2H_Sig && !H2L_Sig;
  end

  initial begin : ref_model
    int  k;
    bit  long_due;
    bit  released;
    wait (rand_on);
    forever begin
      do begin
        @(posedge CLK);
      end while (!h2l_at[(cyc - 1) & M]);
      repeat (T10MS + 1) @(posedge CLK);
      if (pin_at[(cyc - 2) & M]) continue;
      exp_press[cyc & M] = 1'b1;
      m_down   = 1'b1;
      long_due = 1'b1;
      k        = 0;
      released = 1'b0;
      while (!released) begin
        @(posedge CLK);
        k++;
        if (l2h_at[(cyc - 1) & M]) begin
          repeat (T10MS + 1) @(posedge CLK);
          if (pin_at[(cyc - 2) & M]) begin
            exp_rel[cyc & M] = 1'b1;
            m_down   = 1'b0;
            released = 1'b1;
          end else begin
            long_due = 1'b0;
            k        = 0;
          end
        end else if (long_due && k == T_LONG + 1) begin
          exp_long[cyc & M] = 1'b1;
          long_due = 1'b0;
          k        = 0;
        end
`ifdef KEY_REPEAT_EN
        else if (!long_due && k == T_REP + 1) begin
          exp_press[cyc & M] = 1'b1;
          k = 0;
        end
`endif
      end
    end
  end

  always @(negedge CLK) begin
    if (rand_on) begin
      chk("rand_press",   Key_Press,   exp_press[cyc & M]);
      chk("rand_long",    Key_Long,    exp_long[cyc & M]);
      chk("rand_release", Key_Release, exp_rel[cyc & M]);
      chk("rand_state",   Key_State,   m_down);
    end
    cyc++;
  end

  // ------------------------------------------------------------- stimulus
  typedef struct {
    string name;
    int    low_edges;
    bit    exp_press;
  } press_vec_t;

  press_vec_t vecs [4];

  initial begin
    bit st_all;

    vecs[0] = '{"glitch3",  3,  1'b0};
    vecs[1] = '{"short9",   9,  1'b0};
    vecs[2] = '{"edge10",   10, 1'b1};
    vecs[3] = '{"hold40",   40, 1'b1};

    RSTn = 1'b0; Pin_In = 1'b1; H2L_Sig = 1'b0; L2H_Sig = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_press", Key_Press, 0);
    chk("rst_long", Key_Long, 0);
    chk("rst_release", Key_Release, 0);
    chk("rst_state", Key_State, 0);
    RSTn = 1'b1;
    watch(4, 0, 0);
    chk("post_rst_quiet", press_cnt + long_cnt + rel_cnt + int'(st_hist[4]), 0);

    // Table: press debounce outcome vs. how long the pin stays low.
    for (int v = 0; v < 4; v++) begin
      Pin_In  = 1'b0;
      H2L_Sig = 1'b1;
      watch(20, vecs[v].low_edges, 0);
      chk({vecs[v].name, "_press_cnt"}, press_cnt, vecs[v].exp_press ? 1 : 0);
      chk({vecs[v].name, "_state"}, st_hist[20], vecs[v].exp_press);
      if (vecs[v].exp_press) begin
        chk({vecs[v].name, "_press_at"}, press_first, 12);
        chk({vecs[v].name, "_state_before_press"}, st_hist[11], 0);
        do_release(vecs[v].name);
      end
      Pin_In = 1'b1;
      watch(5, 0, 0);
    end

    // Long hold, then release bounce, then real release.
    Pin_In  = 1'b0;
    H2L_Sig = 1'b1;
    watch(92, 0, 0);
    chk("long_press_at", press_first, 12);
    chk("long_at", long_first, 62);
    chk("long_cnt", long_cnt, 1);
    chk("long_press_cnt", press_cnt, 1 + REP);
    chk("long_press_last", press_last, REP ? 82 : 12);
    chk("long_state", st_hist[92], 1);
    chk("long_overlap", overlap_cnt, 0);

    L2H_Sig = 1'b1;
    watch(40, 0, 0);
    st_all = 1'b1;
    for (int i = 1; i <= 40; i++) st_all &= st_hist[i];
    chk("bounce_rel_cnt", rel_cnt, 0);
    chk("bounce_long_cnt", long_cnt, 0);
    chk("bounce_state_held", st_all, 1);
    chk("bounce_repeat_cnt", press_cnt, REP);
    do_release("after_bounce");
    watch(5, 0, 0);

    // Release edge arriving on the long-press terminal clock: release wins.
    Pin_In  = 1'b0;
    H2L_Sig = 1'b1;
    watch(80, 60, 60);
    chk("coll_press_at", press_first, 12);
    chk("coll_long_cnt", long_cnt, 0);
    chk("coll_rel_at", rel_first, 72);
    chk("coll_state_at_rel", st_hist[72], 0);
    watch(5, 0, 0);

    // Release edge one clock later: Key_Long fires first.
    Pin_In  = 1'b0;
    H2L_Sig = 1'b1;
    watch(80, 61, 61);
    chk("late_long_at", long_first, 62);
    chk("late_rel_at", rel_first, 73);
    chk("late_press_cnt", press_cnt, 1);
    watch(5, 0, 0);

    // Reset while pressed: outputs drop at once, no event afterwards.
    Pin_In  = 1'b0;
    H2L_Sig = 1'b1;
    watch(15, 0, 0);
    chk("rstp_state_before", Key_State, 1);
    RSTn = 1'b0;
    #1;
    chk("rstp_state_now", Key_State, 0);
    chk("rstp_outputs_now", int'(Key_Press) + int'(Key_Long) + int'(Key_Release), 0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    watch(30, 0, 0);
    chk("rstp_no_press", press_cnt, 0);
    Pin_In  = 1'b1;
    L2H_Sig = 1'b1;
    watch(20, 0, 0);
    chk("rstp_no_release", rel_cnt, 0);
    chk("rstp_state_after", st_hist[20], 0);

    // Reset five clocks into the press debounce.
    Pin_In  = 1'b0;
    H2L_Sig = 1'b1;
    watch(5, 0, 0);
    RSTn = 1'b0;
    #1;
    chk("rstd_outputs_now",
        int'(Key_Press) + int'(Key_Long) + int'(Key_Release) + int'(Key_State), 0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    watch(30, 0, 0);
    chk("rstd_no_press", press_cnt, 0);
    chk("rstd_state", st_hist[30], 0);
    Pin_In = 1'b1;
    watch(8, 0, 0);

    // Random key activity against the timeline model.
    rand_on = 1'b1;
    for (int ep = 0; ep < 40; ep++) begin
      int lo, hi;
      lo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(13, 110));
      hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(13, 40));
      Pin_In  = 1'b0;
      H2L_Sig = 1'b1;
      L2H_Sig = 1'b0;
      @(negedge CLK);
      for (int i = 1; i < lo; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          H2L_Sig = 1'b1; L2H_Sig = 1'b1;
        end else begin
          H2L_Sig = 1'b0; L2H_Sig = 1'b0;
        end
        @(negedge CLK);
      end
      Pin_In  = 1'b1;
      H2L_Sig = 1'b0;
      L2H_Sig = 1'b1;
      @(negedge CLK);
      for (int i = 1; i < hi; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          H2L_Sig = 1'b1; L2H_Sig = 1'b1;
        end else begin
          H2L_Sig = 1'b0; L2H_Sig = 1'b0;
        end
        @(negedge CLK);
      end
    end
    H2L_Sig = 1'b0;
    L2H_Sig = 1'b0;
    Pin_In  = 1'b1;
    repeat (200) @(negedge CLK);
    chk("rand_final_state", Key_State, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
